cardinal_out_arbiter: RTL and testbench



---
 rtl/cardinal_out_arbiter_pkg.sv | 17 +
 rtl/cardinal_out_arbiter_if.sv | 26 ++
 rtl/cardinal_out_arbiter_rr_arbiter.sv | 36 +++
 rtl/cardinal_out_arbiter.sv | 94 +++++++++
 tb/tb_cardinal_out_arbiter.sv | 132 +++++++++++++
 5 files changed

// File: rtl/cardinal_out_arbiter_pkg.sv
// Shared constants and helpers for the cardinal ring router output-port arbiter.
// Polarity selects which virtual channel is external, and so allowed downstream.
package cardinal_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int N_REQ_DEF      = 3;
    localparam int VC_BIT_DEF     = 0;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    // Polarity 1 exposes the even VC downstream; polarity 0 exposes the odd VC.
    function automatic logic ext_vc(input logic pol);
        return pol ? VC_EVEN : VC_ODD;
    endfunction

endpackage

// File: rtl/cardinal_out_arbiter_if.sv
// Requester and downstream handshake bundle for one cardinal output channel.
// The arbiter uses the slave modport; the requester/downstream side uses master.
interface cardinal_out_arbiter_if
    import cardinal_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_REQ      = N_REQ_DEF
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_gnt;
    logic                        out_so;
    logic                        out_ro;
    logic [DATA_WIDTH-1:0]       out_do;
    logic                        polarity;

    modport slave (
        input  req_valid, req_data, out_ro,
        output req_gnt, out_so, out_do, polarity
    );

    modport master (
        output req_valid, req_data, out_ro,
        input  req_gnt, out_so, out_do, polarity
    );
endinterface

// File: rtl/cardinal_out_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i,
// wrapping modulo N, so N does not have to be a power of two.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] winner_o
);
    logic found;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        // Upper pass covers ptr..N-1, lower pass wraps to 0..ptr-1.
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                winner_o = PTR_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i < int'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                winner_o = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/cardinal_out_arbiter.sv
// Output-port arbiter for one cardinal ring channel: fills the internal-phase VC
// buffer from the requesters while the external-phase VC buffer drains downstream.
module cardinal_out_arbiter
    import cardinal_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_REQ      = N_REQ_DEF,
    parameter int VC_BIT     = VC_BIT_DEF
) (
    input logic                   clk,
    input logic                   reset,
    cardinal_out_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                  pol_q, pol_d;
    logic [1:0]            full_q, full_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [PTR_W-1:0]      rr_q  [2];
    logic [PTR_W-1:0]      rr_d  [2];

    logic                  ext_sel, int_sel;
    logic [N_REQ-1:0]      elig;
    logic [N_REQ-1:0]      arb_gnt;
    logic [PTR_W-1:0]      winner;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  send;

    assign ext_sel = ext_vc(pol_q);
    assign int_sel = ~ext_sel;

    // Only packets for the internal VC compete, and only while its buffer is free.
    always_comb begin
        elig     = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req_valid[i]
                    && (bus.req_data[i*DATA_WIDTH + VC_BIT] == int_sel)
                    && !full_q[int_sel];
            if (arb_gnt[i]) begin
                win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i    (elig),
        .ptr_i    (rr_q[int_sel]),
        .gnt_o    (arb_gnt),
        .winner_o (winner)
    );

    assign send         = reset && full_q[ext_sel];
    assign bus.out_so   = send;
    assign bus.out_do   = send ? buf_q[ext_sel] : '0;
    assign bus.req_gnt  = reset ? arb_gnt : '0;
    assign bus.polarity = pol_q;

    always_comb begin
        pol_d  = ~pol_q;
        full_d = full_q;
        buf_d  = buf_q;
        rr_d   = rr_q;
        if (send && bus.out_ro) begin
            full_d[ext_sel] = 1'b0;
        end
        if (|arb_gnt) begin
            buf_d[int_sel]  = win_data;
            full_d[int_sel] = 1'b1;
            rr_d[int_sel]   = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pol_q    <= 1'b0;
            full_q   <= '0;
            rr_q[0]  <= '0;
            rr_q[1]  <= '0;
        end else begin
            pol_q    <= pol_d;
            full_q   <= full_d;
            rr_q     <= rr_d;
        end
        // NOTE: buffer data is not reset; the full flags alone decide whether it is valid.
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_cardinal_out_arbiter.sv
// Directed, table-driven bench for cardinal_out_arbiter with hand-computed expectations.
module tb_cardinal_out_arbiter;

    typedef struct {
        logic        rst_n;
        logic [2:0]  valid;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] d2;
        logic        ro;
        logic [2:0]  gnt;
        logic        so;
        logic [63:0] dout;
        logic        pol;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    cardinal_out_arbiter_if bus ();

    cardinal_out_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then step past the edge.
    task automatic run_vec(input vec_t v, input string name);
        reset         = v.rst_n;
        bus.req_valid = v.valid;
        bus.req_data  = {v.d2, v.d1, v.d0};
        bus.out_ro    = v.ro;
        @(negedge clk);
        check({name, " req_gnt"},  64'(bus.req_gnt),  64'(v.gnt));
        check({name, " out_so"},   64'(bus.out_so),   64'(v.so));
        check({name, " out_do"},   bus.out_do,        v.dout);
        check({name, " polarity"}, 64'(bus.polarity), 64'(v.pol));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic rst_n, input logic [2:0] valid,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                       input logic ro, input logic [2:0] gnt, input logic so,
                       input logic [63:0] dout, input logic pol, input string name);
        vec_t v;
        v = '{rst_n, valid, d0, d1, d2, ro, gnt, so, dout, pol};
        run_vec(v, name);
    endtask

    vec_t vecs[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset, single VC1 transfer, VC0 round-robin, mixed-VC same-cycle request.
        vecs.push_back('{1'b0, 3'b111, 64'h1, 64'h0, 64'h10, 1'b0, 3'b000, 1'b0, 64'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 64'h1, 64'h0, 64'h10, 1'b0, 3'b000, 1'b0, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 64'h0, 64'h0, 64'h0,  1'b1, 3'b000, 1'b0, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 64'hDEAD_BEEF_0000_0001, 64'h0, 64'h0, 1'b1, 3'b001, 1'b0, 64'h0, 1'b1});
        vecs.push_back('{1'b1, 3'b000, 64'h0, 64'h0, 64'h0,  1'b1, 3'b000, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 64'h0, 64'h0, 64'h0,  1'b1, 3'b000, 1'b0, 64'h0, 1'b1});
        vecs.push_back('{1'b1, 3'b111, 64'h10, 64'h20, 64'h30, 1'b1, 3'b001, 1'b0, 64'h0,  1'b0});
        vecs.push_back('{1'b1, 3'b111, 64'h10, 64'h20, 64'h30, 1'b1, 3'b000, 1'b1, 64'h10, 1'b1});
        vecs.push_back('{1'b1, 3'b111, 64'h10, 64'h20, 64'h30, 1'b1, 3'b010, 1'b0, 64'h0,  1'b0});
        vecs.push_back('{1'b1, 3'b111, 64'h10, 64'h20, 64'h30, 1'b1, 3'b000, 1'b1, 64'h20, 1'b1});
        vecs.push_back('{1'b1, 3'b111, 64'h10, 64'h20, 64'h30, 1'b1, 3'b100, 1'b0, 64'h0,  1'b0});
        vecs.push_back('{1'b1, 3'b111, 64'h10, 64'h20, 64'h30, 1'b1, 3'b000, 1'b1, 64'h30, 1'b1});
        vecs.push_back('{1'b1, 3'b111, 64'h10, 64'h20, 64'h30, 1'b1, 3'b001, 1'b0, 64'h0,  1'b0});
        vecs.push_back('{1'b1, 3'b000, 64'h0, 64'h0, 64'h0,  1'b1, 3'b000, 1'b1, 64'h10, 1'b1});
        vecs.push_back('{1'b1, 3'b000, 64'h0, 64'h0, 64'h0,  1'b1, 3'b000, 1'b0, 64'h0,  1'b0});
        vecs.push_back('{1'b1, 3'b101, 64'hA1, 64'h0, 64'h40, 1'b1, 3'b001, 1'b0, 64'h0,  1'b1});
        vecs.push_back('{1'b1, 3'b100, 64'h0,  64'h0, 64'h40, 1'b1, 3'b100, 1'b1, 64'hA1, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 64'h0, 64'h0, 64'h0,  1'b1, 3'b000, 1'b1, 64'h40, 1'b1});
        vecs.push_back('{1'b1, 3'b000, 64'h0, 64'h0, 64'h0,  1'b1, 3'b000, 1'b0, 64'h0,  1'b0});

        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ro    = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // VC1 stalled by out_ro=0: shown only in polarity 0, held VC1 request never granted.
        cyc(1, 3'b010, 64'h0,  64'hB1, 64'h0, 1, 3'b010, 0, 64'h0,  1, "stall_load");
        cyc(1, 3'b010, 64'h0,  64'hC1, 64'h0, 0, 3'b000, 1, 64'hB1, 0, "stall1");
        cyc(1, 3'b010, 64'h0,  64'hC1, 64'h0, 0, 3'b000, 0, 64'h0,  1, "stall2");
        cyc(1, 3'b010, 64'h0,  64'hC1, 64'h0, 0, 3'b000, 1, 64'hB1, 0, "stall3");
        cyc(1, 3'b010, 64'h0,  64'hC1, 64'h0, 0, 3'b000, 0, 64'h0,  1, "stall4");
        cyc(1, 3'b010, 64'h0,  64'hC1, 64'h0, 0, 3'b000, 1, 64'hB1, 0, "stall5");
        cyc(1, 3'b010, 64'h0,  64'hC1, 64'h0, 0, 3'b000, 0, 64'h0,  1, "stall6");
        cyc(1, 3'b011, 64'h50, 64'hC1, 64'h0, 0, 3'b001, 1, 64'hB1, 0, "vc0_flow_gnt");
        cyc(1, 3'b010, 64'h0,  64'hC1, 64'h0, 1, 3'b000, 1, 64'h50, 1, "vc0_flow_send");
        cyc(1, 3'b000, 64'h0,  64'h0,  64'h0, 1, 3'b000, 1, 64'hB1, 0, "release_send");
        cyc(1, 3'b000, 64'h0,  64'h0,  64'h0, 1, 3'b000, 0, 64'h0,  1, "release_idle");
        cyc(1, 3'b000, 64'h0,  64'h0,  64'h0, 1, 3'b000, 0, 64'h0,  0, "sent_once");

        // Both buffers full, then a one-cycle reset pulse clears state and pointers.
        cyc(1, 3'b001, 64'hD1, 64'h0,  64'h0,  0, 3'b001, 0, 64'h0,  1, "fill_vc1");
        cyc(1, 3'b100, 64'h0,  64'h0,  64'h70, 0, 3'b100, 1, 64'hD1, 0, "fill_vc0");
        cyc(1, 3'b000, 64'h0,  64'h0,  64'h0,  0, 3'b000, 1, 64'h70, 1, "both_full");
        cyc(0, 3'b111, 64'hE1, 64'hE3, 64'hE5, 0, 3'b000, 0, 64'h0,  0, "rst_pulse");
        cyc(1, 3'b111, 64'hE1, 64'hE3, 64'hE5, 0, 3'b000, 0, 64'h0,  0, "post_rst");
        cyc(1, 3'b111, 64'hE1, 64'hE3, 64'hE5, 0, 3'b001, 0, 64'h0,  1, "post_rst_gnt");
        cyc(1, 3'b000, 64'h0,  64'h0,  64'h0,  1, 3'b000, 1, 64'hE1, 0, "post_rst_send");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
